// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (D/I) arbiter for a single-port word memory; optional MEM_ARB_ROUND_ROBIN_EN
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    input  logic              d_req_we,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata,
    output logic              d_rsp_err,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic              i_req_we,
    output logic              i_req_ready,
    output logic              i_rsp_valid,
    output logic [31:0]       i_rsp_rdata,
    output logic              i_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        d_cnt, i_cnt;
    logic              d_grant, i_grant;
    logic              d_aligned, i_aligned;
    logic              win_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [31:0]       hold_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_is_i;
`endif

    assign d_aligned   = (d_req_addr[1:0] == 2'b00);
    assign i_aligned   = (i_req_addr[1:0] == 2'b00);
    assign d_req_ready = d_grant;
    assign i_req_ready = i_grant;
    assign mem_we      = win_we & rst_n;

    // Pick at most one winner: starved port first, then D-over-I or round-robin
    always_comb begin
        d_grant = 1'b0;
        i_grant = 1'b0;
        if (d_req_valid && d_cnt == LIMIT) begin
            d_grant = 1'b1;
        end else if (i_req_valid && i_cnt == LIMIT) begin
            i_grant = 1'b1;
        end else if (d_req_valid && i_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            d_grant = last_is_i;
            i_grant = ~last_is_i;
`else
            d_grant = 1'b1;
`endif
        end else begin
            d_grant = d_req_valid;
            i_grant = i_req_valid;
        end
    end

    // Route the winner to the memory; idle cycles replay the last winner's address/data
    always_comb begin
        mem_addr  = hold_addr;
        mem_wdata = hold_wdata;
        win_we    = 1'b0;
        if (d_grant) begin
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
            win_we    = d_req_we & d_aligned;
        end else if (i_grant) begin
            mem_addr  = i_req_addr;
            mem_wdata = i_req_wdata;
            win_we    = i_req_we & i_aligned;
        end
    end

    // Remember the last winner's address/data so the memory bus stays quiet when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (d_grant || i_grant) begin
            hold_addr  <= mem_addr;
            hold_wdata <= mem_wdata;
        end
    end

    // Count consecutive waiting cycles per port, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_cnt <= '0;
            i_cnt <= '0;
        end else begin
            if (!d_req_valid || d_grant) d_cnt <= '0;
            else if (d_cnt != LIMIT)     d_cnt <= d_cnt + 8'd1;
            if (!i_req_valid || i_grant) i_cnt <= '0;
            else if (i_cnt != LIMIT)     i_cnt <= i_cnt + 8'd1;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Track which port won most recently; starts as I so D wins first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       last_is_i <= 1'b1;
        else if (d_grant) last_is_i <= 1'b0;
        else if (i_grant) last_is_i <= 1'b1;
    end
`endif

    // Register one-cycle responses; writes and misaligned accesses return zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rsp_valid <= 1'b0;
            d_rsp_rdata <= '0;
            d_rsp_err   <= 1'b0;
            i_rsp_valid <= 1'b0;
            i_rsp_rdata <= '0;
            i_rsp_err   <= 1'b0;
        end else begin
            d_rsp_valid <= d_grant;
            d_rsp_err   <= d_grant & ~d_aligned;
            d_rsp_rdata <= (d_grant && !d_req_we && d_aligned) ? mem_rdata : 32'd0;
            i_rsp_valid <= i_grant;
            i_rsp_err   <= i_grant & ~i_aligned;
            i_rsp_rdata <= (i_grant && !i_req_we && i_aligned) ? mem_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic        i_req_valid, i_req_we, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_req_addr, i_req_wdata, i_rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:63];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t d_q[$];
    exp_t i_q[$];

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_we(d_req_we), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
        .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_we(i_req_we), .i_req_ready(i_req_ready), .i_rsp_valid(i_rsp_valid),
        .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expected responses whenever the DUT presents one
    task automatic mon_port(input string p, input logic v, input logic [31:0] rd,
                            input logic err, inout exp_t q[$]);
        exp_t e;
        while (q.size() > 0 && q[0].cyc + 1 < cyc) begin
            e = q.pop_front();
            chk({p, "_rsp_missing"}, 32'd0, 32'd1);
        end
        if (v) begin
            if (q.size() == 0) begin
                chk({p, "_rsp_unexpected"}, 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk({p, "_rsp_latency"}, cyc, e.cyc + 1);
                chk({p, "_rsp_rdata"}, rd, e.rd);
                chk({p, "_rsp_err"}, {31'd0, err}, {31'd0, e.err});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_port("d", d_rsp_valid, d_rsp_rdata, d_rsp_err, d_q);
            mon_port("i", i_rsp_valid, i_rsp_rdata, i_rsp_err, i_q);
        end
    end

    // One bus cycle: drive both ports, check grants and write strobe, queue expected responses
    task automatic step(input logic dv, input logic [31:0] da, input logic [31:0] dwd, input logic dwe,
                        input logic iv, input logic [31:0] ia, input logic [31:0] iwd, input logic iwe,
                        input logic exp_d, input logic exp_i,
                        input logic [31:0] d_rd, input logic [31:0] i_rd);
        exp_t e;
        logic exp_we;
        d_req_valid = dv; d_req_addr = da; d_req_wdata = dwd; d_req_we = dwe;
        i_req_valid = iv; i_req_addr = ia; i_req_wdata = iwd; i_req_we = iwe;
        exp_we = (exp_d && dwe && da[1:0] == 2'b00) || (exp_i && iwe && ia[1:0] == 2'b00);
        @(negedge clk);
        chk("d_req_ready", {31'd0, d_req_ready}, {31'd0, exp_d});
        chk("i_req_ready", {31'd0, i_req_ready}, {31'd0, exp_i});
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        if (exp_d) begin
            e.cyc = cyc; e.rd = d_rd; e.err = (da[1:0] != 2'b00);
            d_q.push_back(e);
        end
        if (exp_i) begin
            e.cyc = cyc; e.rd = i_rd; e.err = (ia[1:0] != 2'b00);
            i_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [0:5] cont1;
    logic [0:4] cont2;

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        cont1 = 6'b101010;
        cont2 = 5'b10101;
`else
        cont1 = 6'b111101;
        cont2 = 5'b11110;
`endif
        for (int k = 0; k < 64; k++) mem[k] = 32'hC0DE_0000 | k;
        rst_n = 1'b0;
        d_req_valid = 0; d_req_addr = 0; d_req_wdata = 0; d_req_we = 0;
        i_req_valid = 0; i_req_addr = 0; i_req_wdata = 0; i_req_we = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        chk("rst_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        chk("rst_d_rsp_rdata", d_rsp_rdata, 32'd0);
        chk("rst_i_rsp_err", {31'd0, i_rsp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back via D
        step(1, 32'h0C, 32'hDEADBEEF, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(1, 32'h0C, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0);
        idle();
        chk("mem_addr_hold", mem_addr, 32'h0C);

        // Misaligned write leaves memory untouched
        step(1, 32'h0D, 32'h12345678, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(1, 32'h0C, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0);

        // Cross-port read-after-write
        step(1, 32'h10, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h10, 32'h0, 0, 0, 1, 32'h0, 32'hA5A5A5A5);

        // Misaligned read on I
        step(0, 0, 0, 0, 1, 32'h22, 32'h0, 0, 0, 1, 32'h0, 32'h0);

        // Continuous contention
        for (int k = 0; k < 6; k++)
            step(1, 32'h0C, 32'h0, 0, 1, 32'h10, 32'h0, 0, cont1[k], !cont1[k],
                 32'hDEADBEEF, 32'hA5A5A5A5);
        idle();

        // Async reset in the middle of traffic
        step(1, 32'h0C, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0);
        d_req_valid = 1; d_req_addr = 32'h14; d_req_wdata = 32'hFFFF0000; d_req_we = 1;
        @(negedge clk);
        chk("pre_rst_d_ready", {31'd0, d_req_ready}, 32'd1);
        chk("pre_rst_mem_we", {31'd0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        chk("mid_rst_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        chk("mid_rst_d_rsp_rdata", d_rsp_rdata, 32'd0);
        d_req_valid = 0; d_req_we = 0;
        d_q.delete();
        i_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++)
            step(1, 32'h14, 32'h0, 0, 1, 32'h0C, 32'h0, 0, cont2[k], !cont2[k],
                 32'hC0DE0005, 32'hDEADBEEF);
        idle();
        idle();

        chk("d_q_drained", d_q.size(), 32'd0);
        chk("i_q_drained", i_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word memory between two requesters: port D (load/store unit) and port I (instruction fetch).
- Each requester uses a valid/ready request channel and a registered response channel.
- The block drives the memory's address, write_data and write_enable. It captures the memory's combinational read_data into a response register, giving 1-cycle latency.
- Contains a per-port starvation counter so a continuously requesting D port cannot lock out fetch forever.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a valid-but-unaccepted requester waits before it is forced to win the next arbitration (legal range 1..255).
- ADDR_W, 32: request and memory address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- d_req_valid  in  1  port D request valid
- d_req_addr  in  ADDR_W  port D byte address
- d_req_wdata  in  32  port D write data
- d_req_we  in  1  port D write (1) or read (0)
- d_req_ready  out  1  port D request accepted this cycle
- d_rsp_valid  out  1  port D response valid, 1-cycle pulse
- d_rsp_rdata  out  32  port D read data
- d_rsp_err  out  1  port D misaligned access
- i_req_valid, i_req_addr, i_req_wdata, i_req_we, i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err: same as port D, for port I
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset (async, rst_n=0):
  - all *_rsp_valid, *_rsp_err = 0; *_rsp_rdata = 0.
  - starvation counters = 0; last-grant = I; mem_we forced 0.
- Arbitration is combinational each cycle. At most one grant per cycle. *_req_ready is asserted only for the winner and only when that port's req_valid = 1.
- Default priority: D over I.
- Starvation override: if a port's counter has reached STARVE_LIMIT, that port wins regardless of priority.
- Starvation counter, per port:
  - increments when req_valid=1 and ready=0;
  - clears on accept or when req_valid=0;
  - saturates at STARVE_LIMIT.
- Memory drive:
  - mem_addr and mem_wdata come from the winner. With no winner, they hold the last winner's values (no toggling).
  - mem_we = winner we AND aligned, where aligned means addr[1:0]==2'b00. The write commits at that posedge.
- Response timing: on the accepting posedge, the winner's rsp register loads rsp_valid=1 for exactly one cycle (next cycle).
  - rsp_rdata = mem_rdata for reads; 0 for writes and misaligned accesses.
  - rsp_err = misaligned.
  - A port that is not accepted gets rsp_valid=0 in the following cycle.
- Misaligned access (addr[1:0]!=0): accepted normally; mem_we suppressed; memory content unchanged.
- Throughput: one accept per cycle. Back-to-back accepts on the same port give back-to-back rsp_valid pulses.
- Requesters must hold valid, addr, wdata and we stable until ready. The block does not latch unaccepted requests.
- Reset mid-operation: a pending response is dropped (rsp_valid=0). An in-flight write in the reset cycle is not issued, because mem_we is forced 0 while rst_n=0.
- Read-after-write to the same address from the other port, accepted on the next cycle: returns the new data.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - the D-over-I priority is replaced by round-robin. When both ports are valid, the port that did not win most recently wins.
  - last-grant updates on every accept.
  - the starvation override still applies and takes precedence.
- Not defined: fixed D-over-I priority; last-grant state is not implemented.

Test Plan:
- Single read, D only: write mem[3]=0xDEADBEEF via D (addr 0x0C, we=1), then D read addr 0x0C → d_req_ready=1 same cycle; next cycle d_rsp_valid=1, d_rsp_rdata=0xDEADBEEF, d_rsp_err=0; i_rsp_valid=0.
- Contention, fixed priority, STARVE_LIMIT=4: D and I valid continuously → D accepted for 4 cycles; I accepted on cycle 5 (counter=4); D accepted again on cycle 6.
- Round-robin (MEM_ARB_ROUND_ROBIN_EN): both ports valid for 6 cycles → grants alternate D,I,D,I,D,I (last-grant=I at reset, so D first).
- Misaligned write: D write addr 0x0D, data 0x12345678 → mem_we=0; next cycle d_rsp_valid=1, d_rsp_err=1, d_rsp_rdata=0; a subsequent read of 0x0C returns its prior value.
- Cross-port RAW: D write 0x10←0xA5A5A5A5 accepted at cycle N; I read 0x10 accepted at cycle N+1 → i_rsp_rdata=0xA5A5A5A5 at N+2.
- Async reset mid-traffic: assert rst_n=0 between clock edges while a D read is accepted → all rsp_valid and mem_we drop to 0 immediately; after release, starvation counters are 0 and the first contended grant is D.
